// File: rtl/pipe_stage_chain.sv
// Parametrised pipeline register chain with per-stage valid, stall and flush,
// output backpressure, optional bubble-collapse, and saturating hazard counters.
module pipe_stage_chain #(
    parameter int WIDTH    = 32,
    parameter int STAGES   = 4,
    parameter int COLLAPSE = 0
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    input  logic [WIDTH-1:0]          in_data,
    output logic                      in_ready,
    input  logic [STAGES-1:0]         stall_req,
    input  logic [STAGES-1:0]         flush_req,
    input  logic                      out_ready,
    output logic                      out_valid,
    output logic [WIDTH-1:0]          out_data,
    output logic [STAGES-1:0]         stage_valid,
    output logic [STAGES*WIDTH-1:0]   stage_data,
    input  logic                      clr_stats,
    output logic [15:0]               stall_cnt,
    output logic [15:0]               flush_cnt
);

    function automatic logic [15:0] sat_inc(input logic [15:0] c);
        return (c == 16'hFFFF) ? c : c + 16'd1;
    endfunction

    logic [WIDTH-1:0]  data_p [STAGES];
    logic [STAGES-1:0] vld_p;
    logic [STAGES-1:0] hold;
    logic [STAGES-1:0] kill;
    logic [15:0]       stall_cnt_r;
    logic [15:0]       flush_cnt_r;

    // Hold propagates from the consumer toward stage 0; kill accumulates from the oldest stage down.
    always_comb begin
        logic h;
        logic k;
        h    = ~out_ready;
        k    = 1'b0;
        hold = '0;
        kill = '0;
        for (int i = STAGES - 1; i >= 0; i--) begin
            if (COLLAPSE != 0) begin
                h = stall_req[i] | (vld_p[i] & h);
            end else begin
                h = stall_req[i] | h;
            end
            hold[i] = h;
            k       = k | flush_req[i];
            kill[i] = k;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p <= '0;
            for (int i = 0; i < STAGES; i++) begin
                data_p[i] <= '0;
            end
        end else begin
            if (hold[0]) begin
                vld_p[0] <= vld_p[0] & ~kill[0];
            end else begin
                data_p[0] <= in_data;
                vld_p[0]  <= in_valid & ~kill[0];
            end
            // Flush clears valid even on held stages; data only moves when the stage advances.
            for (int i = 1; i < STAGES; i++) begin
                if (hold[i]) begin
                    vld_p[i] <= vld_p[i] & ~kill[i];
                end else if (hold[i-1]) begin
                    vld_p[i] <= 1'b0;
                end else begin
                    data_p[i] <= data_p[i-1];
                    vld_p[i]  <= vld_p[i-1] & ~kill[i-1];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst || clr_stats) begin
            stall_cnt_r <= '0;
            flush_cnt_r <= '0;
        end else begin
            if (in_valid && hold[0]) begin
                stall_cnt_r <= sat_inc(stall_cnt_r);
            end
            if (|flush_req) begin
                flush_cnt_r <= sat_inc(flush_cnt_r);
            end
        end
    end

    assign in_ready    = ~hold[0];
    assign out_valid   = vld_p[STAGES-1];
    assign out_data    = data_p[STAGES-1];
    assign stage_valid = vld_p;
    assign stall_cnt   = stall_cnt_r;
    assign flush_cnt   = flush_cnt_r;

    for (genvar g = 0; g < STAGES; g++) begin : g_pack
        assign stage_data[g*WIDTH +: WIDTH] = data_p[g];
    end

endmodule
